// File: rtl/lab1_imul_int_mul_shared_arb.sv
// Round-robin arbiter sharing one iterative multiplier among NREQ clients.
// Define LAB1_IMUL_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module lab1_imul_int_mul_shared_arb #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_val,
  output logic [NREQ-1:0]   req_rdy,
  input  logic [64*NREQ-1:0] req_msg,
  output logic [NREQ-1:0]   resp_val,
  input  logic [NREQ-1:0]   resp_rdy,
  output logic [32*NREQ-1:0] resp_msg,
  output logic              mul_req_val,
  input  logic              mul_req_rdy,
  output logic [63:0]       mul_req_msg,
  input  logic              mul_resp_val,
  output logic              mul_resp_rdy,
  input  logic [31:0]       mul_resp_msg
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [OW-1:0] owner;
  logic [OW-1:0] ptr;
  logic [OW-1:0] ptr_nxt;
  logic [63:0]   msg_reg;
  logic [31:0]   res_reg;

  logic [OW-1:0] grant;
  logic          any_val;
  logic          req_fire;
  logic          mresp_fire;

  // Walk the search order backwards so the last hit is the first in order.
  always_comb begin
    grant   = '0;
    any_val = 1'b0;
`ifdef LAB1_IMUL_ARB_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_val[k]) begin
        grant   = OW'(k);
        any_val = 1'b1;
      end
    end
`else
    for (int k = NREQ - 1; k >= 0; k--) begin
      logic [OW:0]   sum;
      logic [OW-1:0] cand;
      sum = {1'b0, ptr} + (OW+1)'(k);
      if (sum >= (OW+1)'(NREQ))
        sum = sum - (OW+1)'(NREQ);
      cand = sum[OW-1:0];
      if (req_val[cand]) begin
        grant   = cand;
        any_val = 1'b1;
      end
    end
`endif
  end

`ifdef LAB1_IMUL_ARB_FIXED_PRIO_EN
  assign ptr_nxt = '0;
`else
  assign ptr_nxt = (grant == OW'(NREQ - 1)) ? '0 : grant + 1'b1;
`endif

  assign req_fire   = (state == IDLE) && any_val;
  assign mresp_fire = (state == WAIT) && mul_resp_val;

  always_comb begin
    state_nxt    = state;
    req_rdy      = '0;
    resp_val     = '0;
    resp_msg     = '0;
    mul_req_val  = 1'b0;
    mul_resp_rdy = 1'b0;
    mul_req_msg  = msg_reg;
    unique case (state)
      IDLE: begin
        if (any_val) begin
          req_rdy[grant] = 1'b1;
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        mul_req_val = 1'b1;
        if (mul_req_rdy)
          state_nxt = WAIT;
      end
      WAIT: begin
        mul_resp_rdy = 1'b1;
        if (mul_resp_val)
          state_nxt = RESP;
      end
      RESP: begin
        resp_val[owner]           = 1'b1;
        resp_msg[32*owner +: 32] = res_reg;
        if (resp_rdy[owner])
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner   <= '0;
      ptr     <= '0;
      msg_reg <= '0;
      res_reg <= '0;
    end else begin
      state <= state_nxt;
      if (req_fire) begin
        owner   <= grant;
        msg_reg <= req_msg[64*grant +: 64];
        ptr     <= ptr_nxt;
      end
      if (mresp_fire)
        res_reg <= mul_resp_msg;
    end
  end

endmodule

// File: tb/tb_lab1_imul_int_mul_shared_arb.sv
// Directed bench for the shared multiplier arbiter with a behavioural
// variable-latency multiplier on the far side.
module tb_lab1_imul_int_mul_shared_arb;

  localparam int NREQ = 4;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req_val;
  logic [NREQ-1:0]   req_rdy;
  logic [64*NREQ-1:0] req_msg;
  logic [NREQ-1:0]   resp_val;
  logic [NREQ-1:0]   resp_rdy;
  logic [32*NREQ-1:0] resp_msg;
  logic              mul_req_val;
  logic              mul_req_rdy;
  logic [63:0]       mul_req_msg;
  logic              mul_resp_val;
  logic              mul_resp_rdy;
  logic [31:0]       mul_resp_msg;

  int total;
  int bad;

  lab1_imul_int_mul_shared_arb #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_msg      (req_msg),
    .resp_val     (resp_val),
    .resp_rdy     (resp_rdy),
    .resp_msg     (resp_msg),
    .mul_req_val  (mul_req_val),
    .mul_req_rdy  (mul_req_rdy),
    .mul_req_msg  (mul_req_msg),
    .mul_resp_val (mul_resp_val),
    .mul_resp_rdy (mul_resp_rdy),
    .mul_resp_msg (mul_resp_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: fixed or random latency, optional random req stalls
  logic        busy;
  int          cnt;
  logic [31:0] prod;
  int          lat_cfg;
  bit          rand_mode;
  logic        stall;

  assign mul_req_rdy  = !busy && !stall;
  assign mul_resp_val = busy && (cnt == 0);
  assign mul_resp_msg = prod;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      cnt  <= 0;
      prod <= '0;
    end else if (mul_req_val && mul_req_rdy) begin
      busy <= 1'b1;
      prod <= mul_req_msg[63:32] * mul_req_msg[31:0];
      cnt  <= (rand_mode ? int'($urandom_range(1, 5)) : lat_cfg) - 1;
    end else if (busy && cnt > 0) begin
      cnt <= cnt - 1;
    end else if (mul_resp_val && mul_resp_rdy) begin
      busy <= 1'b0;
    end
  end

  always @(posedge clk)
    stall <= rand_mode ? ($urandom_range(0, 2) == 0) : 1'b0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Operand pair must hold while the multiplier has not taken it
  logic        prev_mv;
  logic [63:0] prev_mm;
  initial prev_mv = 1'b0;
  always @(negedge clk) begin
    if (reset && mul_req_val) begin
      if (prev_mv)
        chk("mreq_hold", 128'(mul_req_msg), 128'(prev_mm));
      prev_mv = 1'b1;
      prev_mm = mul_req_msg;
    end else begin
      prev_mv = 1'b0;
    end
  end

  task automatic send(input int i, input logic [31:0] a,
                      input logic [31:0] b);
    int n;
    @(negedge clk);
    req_val[i]            = 1'b1;
    req_msg[64*i +: 64] = {a, b};
    #1;
    n = 0;
    while (!req_rdy[i] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant", 128'(req_rdy), 128'(1) << i);
    @(negedge clk);
    req_val[i] = 1'b0;
  endtask

  task automatic recv(input int i, input logic [31:0] exp);
    int n;
    n = 0;
    #1;
    while (!resp_val[i] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("resp_val", 128'(resp_val), 128'(1) << i);
    chk("resp_msg", 128'(resp_msg), 128'(exp) << (32 * i));
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    #1;
    while (req_rdy == '0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    #1;
    while (resp_val == '0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_req_rdy", 128'(req_rdy), 128'(0));
    chk("rst_resp_val", 128'(resp_val), 128'(0));
    chk("rst_resp_msg", 128'(resp_msg), 128'(0));
    chk("rst_mreq_val", 128'(mul_req_val), 128'(0));
    chk("rst_mreq_msg", 128'(mul_req_msg), 128'(0));
    chk("rst_mresp_rdy", 128'(mul_resp_rdy), 128'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [NREQ-1:0] g;

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    req_val   = '0;
    req_msg   = '0;
    resp_rdy  = '1;
    lat_cfg   = 2;
    rand_mode = 1'b0;
    do_reset();

    // Single request, L=2: response exactly four cycles after fire
    @(negedge clk);
    req_val[0]     = 1'b1;
    req_msg[63:0] = {32'd3, 32'd7};
    #1;
    chk("t1_grant", 128'(req_rdy), 128'(1));
    @(negedge clk);
    req_val[0] = 1'b0;
    #1;
    chk("t1_mreq_val", 128'(mul_req_val), 128'(1));
    chk("t1_mreq_msg", 128'(mul_req_msg), {64'd0, 32'd3, 32'd7});
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t1_early", 128'(resp_val), 128'(0));
    @(negedge clk);
    #1;
    chk("t1_resp_val", 128'(resp_val), 128'(1));
    chk("t1_resp_msg", 128'(resp_msg), 128'd21);

    // All four at once: strict order 0..3, then pointer wraps to 0
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++)
      req_msg[64*i +: 64] = {32'(i + 1), 32'(i + 2)};
    req_val = '1;
    for (int e = 0; e < NREQ; e++) begin
      wait_rdy();
      g = req_rdy;
      chk("t2_order", 128'(g), 128'(1) << e);
      @(negedge clk);
      req_val = req_val & ~g;
      wait_resp();
      chk("t2_resp_val", 128'(resp_val), 128'(1) << e);
      chk("t2_resp_msg", 128'(resp_msg),
          128'((e + 1) * (e + 2)) << (32 * e));
      @(negedge clk);
    end
    @(negedge clk);
    req_val       = 4'b0101;
    req_msg[63:0] = {32'd9, 32'd9};
    #1;
    chk("t2_wrap", 128'(req_rdy), 128'(1));
    @(negedge clk);
    req_val = '0;
    recv(0, 32'd81);

    // Backpressure on requester 1 blocks requester 2
    send(1, 32'd5, 32'd6);
    resp_rdy[1]         = 1'b0;
    req_val[2]          = 1'b1;
    req_msg[128 +: 64] = {32'h0001_0000, 32'h0001_0001};
    wait_resp();
    for (int c = 0; c < 5; c++) begin
      chk("t3_blocked", 128'(req_rdy), 128'(0));
      chk("t3_hold", 128'(resp_msg), 128'd30 << 32);
      @(negedge clk);
      #1;
    end
    resp_rdy[1] = 1'b1;
    @(negedge clk);
    #1;
    chk("t3_accept", 128'(req_rdy), 128'(4));
    @(negedge clk);
    req_val[2] = 1'b0;
    recv(2, 32'h0001_0000);

    // Random stalls and latencies; full-width operands
    rand_mode = 1'b1;
    send(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    recv(3, 32'h0000_0001);
    send(0, 32'h1234_5678, 32'd9);
    recv(0, 32'hA3D7_0A38);
    send(1, 32'h8000_0000, 32'd2);
    recv(1, 32'h0000_0000);
    rand_mode = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset pulsed during WAIT discards the transaction
    lat_cfg = 6;
    send(2, 32'd7, 32'd8);
    begin
      int n;
      n = 0;
      while (!mul_resp_rdy && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t5_in_wait", 128'(mul_resp_rdy), 128'(1));
    end
    #2;
    reset = 1'b0;
    #1;
    chk("t5_mresp_rdy", 128'(mul_resp_rdy), 128'(0));
    chk("t5_mreq_msg", 128'(mul_req_msg), 128'(0));
    chk("t5_resp_val", 128'(resp_val), 128'(0));
    chk("t5_ptr", 128'(dut.ptr), 128'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      chk("t5_no_resp", 128'(resp_val), 128'(0));
    end
    lat_cfg = 2;
    send(3, 32'd11, 32'd13);
    recv(3, 32'd143);

    // Requesters 0 and 2 held valid continuously
    @(negedge clk);
    req_msg[63:0]       = {32'd2, 32'd3};
    req_msg[128 +: 64] = {32'd4, 32'd5};
    req_val             = 4'b0101;
    for (int t = 0; t < 3; t++) begin
      wait_rdy();
`ifdef LAB1_IMUL_ARB_FIXED_PRIO_EN
      chk("t6_grant", 128'(req_rdy), 128'(1));
`else
      chk("t6_grant", 128'(req_rdy), (t == 1) ? 128'(4) : 128'(1));
`endif
      @(negedge clk);
      wait_resp();
`ifdef LAB1_IMUL_ARB_FIXED_PRIO_EN
      chk("t6_resp", 128'(resp_msg), 128'd6);
`else
      chk("t6_resp", 128'(resp_msg),
          (t == 1) ? (128'd20 << 64) : 128'd6);
`endif
      @(negedge clk);
    end
    req_val = '0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
